// File: rtl/dds_top.sv
// ---------------------------------------------------------------------------
// dds_top
// Purpose : DDS demo top level. A quadrature rotary encoder sets a decimal
//           tuning word (0..TW_MAX). A phase accumulator driven by that word
//           produces a square wave. The tuning word is shown in decimal on a
//           4-digit multiplexed 7-segment display.
// Ports   : Clock       - system clock, rising edge
//           Reset       - asynchronous, active-low reset
//           EncoderA_i  - encoder channel A (async, idle high)
//           EncoderB_i  - encoder channel B (async, idle high)
//           Signal_o    - DDS square-wave output (accumulator MSB, registered)
//           Cathodes_o  - digit select, one-hot active-low, bit0 = units
//           Segments_o  - segments {dp,g,f,e,d,c,b,a}, active-low, dp off
// ---------------------------------------------------------------------------
module dds_top #(
  parameter int CLOCK_HZ        = 25_000_000,
  parameter int ACC_W           = 16,
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int REFRESH_CYCLES  = CLOCK_HZ / 1000,
  parameter int TW_MAX          = 9999
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       EncoderA_i,
  input  logic       EncoderB_i,
  output logic       Signal_o,
  output logic [3:0] Cathodes_o,
  output logic [7:0] Segments_o
);

  localparam int TW_W = $clog2(TW_MAX + 1);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RF_W = $clog2(REFRESH_CYCLES + 1);

  localparam logic [TW_W-1:0] TW_MAX_V   = TW_W'(TW_MAX);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RF_W-1:0] RF_LAST    = RF_W'(REFRESH_CYCLES - 1);

  // Channel 0 = A, channel 1 = B
  logic [1:0]            w_pins;
  logic [1:0]            r_meta;
  logic [1:0]            r_sync;
  logic [1:0]            r_deb;
  logic [1:0][DB_W-1:0]  r_dbCnt;
  logic                  r_aPrev;

  logic                  w_fall;
  logic                  w_inc;
  logic                  w_dec;
  logic                  w_carry;

  logic [TW_W-1:0]       r_tuningWord;
  logic [3:0][3:0]       r_digits;
  logic [3:0][3:0]       w_digitsNext;

  logic [ACC_W-1:0]      r_acc;
  logic                  r_signal;

  logic [RF_W-1:0]       r_refresh;
  logic [1:0]            r_idx;
  logic [3:0]            r_cathodes;
  logic [7:0]            r_segments;

  function automatic logic [7:0] segDecode(input logic [3:0] digit);
    case (digit)
      4'd0:    segDecode = 8'hC0;
      4'd1:    segDecode = 8'hF9;
      4'd2:    segDecode = 8'hA4;
      4'd3:    segDecode = 8'hB0;
      4'd4:    segDecode = 8'h99;
      4'd5:    segDecode = 8'h92;
      4'd6:    segDecode = 8'h82;
      4'd7:    segDecode = 8'hF8;
      4'd8:    segDecode = 8'h80;
      4'd9:    segDecode = 8'h90;
      default: segDecode = 8'hFF;
    endcase
  endfunction

  assign w_pins = {EncoderB_i, EncoderA_i};

  // Synchronizers and debouncers reset to the idle-high level so that
  // leaving reset never looks like a falling edge on A.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_meta  <= 2'b11;
      r_sync  <= 2'b11;
      r_deb   <= 2'b11;
      r_dbCnt <= '0;
      r_aPrev <= 1'b1;
    end else begin
      r_meta  <= w_pins;
      r_sync  <= r_meta;
      r_aPrev <= r_deb[0];
      for (int c = 0; c < 2; c++) begin
        if (r_sync[c] == r_deb[c]) begin
          r_dbCnt[c] <= '0;
        end else if (r_dbCnt[c] == DB_LAST) begin
          r_deb[c]   <= r_sync[c];
          r_dbCnt[c] <= '0;
        end else begin
          r_dbCnt[c] <= r_dbCnt[c] + 1'b1;
        end
      end
    end
  end

  // One step per debounced falling edge of A; B selects the direction.
  assign w_fall = r_aPrev & ~r_deb[0];
  assign w_inc  = w_fall &  r_deb[1] & (r_tuningWord != TW_MAX_V);
  assign w_dec  = w_fall & ~r_deb[1] & (r_tuningWord != '0);

  // Ripple carry/borrow through the BCD digits, units first.
  always_comb begin
    w_digitsNext = r_digits;
    w_carry      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (w_inc) begin
          if (r_digits[i] == 4'd9) begin
            w_digitsNext[i] = 4'd0;
          end else begin
            w_digitsNext[i] = r_digits[i] + 4'd1;
            w_carry         = 1'b0;
          end
        end else if (w_dec) begin
          if (r_digits[i] == 4'd0) begin
            w_digitsNext[i] = 4'd9;
          end else begin
            w_digitsNext[i] = r_digits[i] - 4'd1;
            w_carry         = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_tuningWord <= '0;
      r_digits     <= '0;
    end else begin
      if (w_inc) begin
        r_tuningWord <= r_tuningWord + 1'b1;
      end else if (w_dec) begin
        r_tuningWord <= r_tuningWord - 1'b1;
      end
      r_digits <= w_digitsNext;
    end
  end

  // Phase accumulator wraps naturally modulo 2^ACC_W.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_acc    <= '0;
      r_signal <= 1'b0;
    end else begin
      r_acc    <= r_acc + ACC_W'(r_tuningWord);
      r_signal <= r_acc[ACC_W-1];
    end
  end

  // Display scan: cathode and segments are registered together from the
  // same digit index, so they always switch in the same cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_refresh  <= '0;
      r_idx      <= 2'd0;
      r_cathodes <= 4'b1110;
      r_segments <= 8'hC0;
    end else begin
      if (r_refresh == RF_LAST) begin
        r_refresh <= '0;
        r_idx     <= r_idx + 2'd1;
      end else begin
        r_refresh <= r_refresh + 1'b1;
      end
      r_cathodes <= ~(4'b0001 << r_idx);
      r_segments <= segDecode(r_digits[r_idx]);
    end
  end

  assign Signal_o   = r_signal;
  assign Cathodes_o = r_cathodes;
  assign Segments_o = r_segments;

endmodule

// File: tb/tb_dds_top.sv
// ---------------------------------------------------------------------------
// tb_dds_top
// Purpose : Self-checking bench for dds_top with shortened debounce, refresh
//           and saturation parameters. Encoder stimulus comes from a vector
//           table; each vector pushes its expected tuning word to a queue
//           which is popped when the display and word are checked.
// ---------------------------------------------------------------------------
module tb_dds_top;

  localparam int DEB   = 4;
  localparam int REF   = 4;
  localparam int ACCW  = 12;
  localparam int TWMAX = 1002;
  localparam int HOLD  = DEB + 4;

  localparam int ACT_UP     = 0;
  localparam int ACT_DOWN   = 1;
  localparam int ACT_FAST   = 2;
  localparam int ACT_GLITCH = 3;

  typedef struct {
    int    action;
    int    count;
    int    expTw;
    string name;
  } vec_t;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       EncA;
  logic       EncB;
  logic       Signal_o;
  logic [3:0] Cathodes_o;
  logic [7:0] Segments_o;

  int   testsRun    = 0;
  int   testsFailed = 0;
  int   expQ[$];
  vec_t vecs[15];
  logic [7:0] segTable[10];

  dds_top #(
    .CLOCK_HZ       (25_000_000),
    .ACC_W          (ACCW),
    .DEBOUNCE_CYCLES(DEB),
    .REFRESH_CYCLES (REF),
    .TW_MAX         (TWMAX)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .EncoderA_i(EncA),
    .EncoderB_i(EncB),
    .Signal_o  (Signal_o),
    .Cathodes_o(Cathodes_o),
    .Segments_o(Segments_o)
  );

  always #5 Clock = ~Clock;

  // Absolute time limit so a stuck design still produces a summary.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic setPins(input logic a, input logic b);
    EncA = a;
    EncB = b;
    waitCycles(HOLD);
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < v.count; i++) begin
      case (v.action)
        ACT_UP: begin
          setPins(1'b0, 1'b1); setPins(1'b0, 1'b0); setPins(1'b1, 1'b0); setPins(1'b1, 1'b1);
        end
        ACT_DOWN: begin
          setPins(1'b1, 1'b0); setPins(1'b0, 1'b0); setPins(1'b0, 1'b1); setPins(1'b1, 1'b1);
        end
        ACT_FAST: begin
          setPins(1'b0, 1'b1); setPins(1'b1, 1'b1);
        end
        default: begin
          EncA = 1'b0;
          waitCycles(DEB - 2);
          EncA = 1'b1;
          waitCycles(HOLD);
        end
      endcase
    end
    expQ.push_back(v.expTw);
  endtask

  // Walks the scan and compares each digit's segments with the table.
  task automatic checkDisplay(input string name, input int value);
    int divisor = 1;
    for (int d = 0; d < 4; d++) begin
      logic [3:0] pat;
      int k = 0;
      int digit = (value / divisor) % 10;
      pat = ~(4'b0001 << d);
      while (Cathodes_o !== pat && k < 8 * REF) begin
        @(negedge Clock);
        k++;
      end
      check($sformatf("%s_cath%0d", name, d), {28'd0, Cathodes_o}, {28'd0, pat});
      check($sformatf("%s_seg%0d", name, d), {24'd0, Segments_o}, {24'd0, segTable[digit]});
      divisor = divisor * 10;
    end
  endtask

  task automatic checkOutput(input string name);
    int exp;
    if (expQ.size() == 0) begin
      check({name, "_queue"}, 32'd0, 32'd1);
    end else begin
      exp = expQ.pop_front();
      check({name, "_tw"}, 32'(dut.r_tuningWord), exp);
      checkDisplay(name, exp);
    end
  endtask

  task automatic countToggles(input int cycles, output int toggles);
    logic prev;
    toggles = 0;
    prev = Signal_o;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clock);
      if (Signal_o !== prev) toggles++;
      prev = Signal_o;
    end
  endtask

  initial begin
    int toggles;
    int k;
    logic [3:0] cur;
    logic [3:0] nextPat[3];

    segTable = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    nextPat  = '{4'b1011, 4'b0111, 4'b1110};

    vecs[0]  = '{ACT_UP,     10,   10,   "up10"};
    vecs[1]  = '{ACT_DOWN,   3,    7,    "down3"};
    vecs[2]  = '{ACT_DOWN,   7,    0,    "down7"};
    vecs[3]  = '{ACT_DOWN,   1,    0,    "sat_zero"};
    vecs[4]  = '{ACT_GLITCH, 1,    0,    "glitch"};
    vecs[5]  = '{ACT_UP,     9,    9,    "up9"};
    vecs[6]  = '{ACT_UP,     1,    10,   "carry_9_10"};
    vecs[7]  = '{ACT_FAST,   90,   100,  "fast90"};
    vecs[8]  = '{ACT_DOWN,   1,    99,   "borrow_100_99"};
    vecs[9]  = '{ACT_FAST,   900,  999,  "fast900"};
    vecs[10] = '{ACT_FAST,   1,    1000, "carry_999_1000"};
    vecs[11] = '{ACT_DOWN,   1,    999,  "borrow_1000_999"};
    vecs[12] = '{ACT_FAST,   3,    1002, "to_max"};
    vecs[13] = '{ACT_FAST,   1,    1002, "sat_max_fast"};
    vecs[14] = '{ACT_UP,     1,    1002, "sat_max_quad"};

    // Reset state
    EncA  = 1'b1;
    EncB  = 1'b1;
    Reset = 1'b0;
    waitCycles(3);
    check("rst_cath", {28'd0, Cathodes_o}, 32'h0000_000E);
    check("rst_seg", {24'd0, Segments_o}, 32'h0000_00C0);
    check("rst_sig", {31'd0, Signal_o}, 32'd0);
    Reset = 1'b1;

    // Scan timing from reset: each digit selected for REF cycles in order
    k = 0;
    while (Cathodes_o !== 4'b1101 && k < 8 * REF) begin
      @(negedge Clock);
      k++;
    end
    check("scan_first", {28'd0, Cathodes_o}, 32'h0000_000D);
    for (int p = 0; p < 3; p++) begin
      cur = Cathodes_o;
      k = 0;
      while (Cathodes_o === cur && k < 8 * REF) begin
        @(negedge Clock);
        k++;
      end
      check($sformatf("scan_len%0d", p), k, REF);
      check($sformatf("scan_next%0d", p), {28'd0, Cathodes_o}, {28'd0, nextPat[p]});
    end

    // Idle encoder with TW=0: constant low output, display 0000
    countToggles(256, toggles);
    check("idle_toggles", toggles, 0);
    check("idle_sig", {31'd0, Signal_o}, 32'd0);
    checkDisplay("idle", 0);

    // Table-driven encoder vectors
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name);
    end

    // Over 2^ACCW cycles the MSB toggles exactly 2*TW times
    countToggles(1 << ACCW, toggles);
    check("toggles_max", toggles, 2 * TWMAX);

    // Reset pulse mid-scan clears everything without a clock edge
    k = 0;
    while (Cathodes_o !== 4'b1011 && k < 8 * REF) begin
      @(negedge Clock);
      k++;
    end
    #1 Reset = 1'b0;
    #1;
    check("midrst_cath", {28'd0, Cathodes_o}, 32'h0000_000E);
    check("midrst_seg", {24'd0, Segments_o}, 32'h0000_00C0);
    check("midrst_tw", 32'(dut.r_tuningWord), 32'd0);
    check("midrst_sig", {31'd0, Signal_o}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    waitCycles(2);

    // Step latency: pin edge to tuning-word change is DEB+3 cycles
    EncA = 1'b0;
    EncB = 1'b1;
    k = 0;
    while (dut.r_tuningWord == '0 && k < 50) begin
      @(negedge Clock);
      k++;
    end
    check("latency", k, DEB + 3);
    waitCycles(HOLD);
    EncA = 1'b1;
    waitCycles(HOLD);
    check("latency_tw", 32'(dut.r_tuningWord), 32'd1);

    // Back to TW=10 and check output frequency
    applyStimulus('{ACT_UP, 9, 10, "post_rst_up9"});
    checkOutput("post_rst_up9");
    countToggles(1 << ACCW, toggles);
    check("toggles_10", toggles, 20);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
